seq_multiplier: RTL

- Iterative shift-add unsigned multiplier. Produces a registered 2*WORD_LENGTH-bit product with a start/busy/done handshake.
- Sits directly upstream of the datapath 2-to-1 selection stage:
  - product drives that stage's data-1 input.
  - done/busy let control logic steer its selector.
- Fixed latency, one multiplier bit per clock, so timing is deterministic for the control FSM.

---
 rtl/seq_multiplier.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Iterative shift-add unsigned multiplier. One multiplier bit is
//            consumed per clock, so latency is fixed at WORD_LENGTH+1 edges
//            from the accepting edge to the done pulse.
// Ports    : clk          - system clock, rising-edge active
//            reset        - asynchronous, active-high reset
//            start        - operation request, sampled only while idle
//            multiplicand - operand A (unsigned, WORD_LENGTH bits)
//            multiplier   - operand B (unsigned, WORD_LENGTH bits)
//            product      - registered A*B of the last completed operation
//            busy         - high while an operation is in RUN or DONE
//            done         - one-cycle pulse when product has just updated
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       busy,
  output logic                       done
);

  localparam int PROD_W = 2 * WORD_LENGTH;
  // Counter needs to hold WORD_LENGTH-1; keep at least one bit for tiny widths.
  localparam int CNT_W  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [PROD_W-1:0]    mcand_q,   mcand_d;
  logic [WORD_LENGTH-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0]    acc_q,     acc_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [PROD_W-1:0]    product_q, product_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;

  // Partial-product add for the current multiplier bit. Used both as the
  // next accumulator value and, on the last RUN edge, as the final product,
  // so the last accumulate is never skipped.
  logic [PROD_W-1:0]    addend;
  logic [PROD_W-1:0]    acc_sum;

  always_comb begin
    addend  = mplier_q[0] ? mcand_q : '0;
    acc_sum = acc_q + addend;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mcand_d  = {{WORD_LENGTH{1'b0}}, multiplicand};
          mplier_d = multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        busy_d   = 1'b1;
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Registering product/done here makes them visible during DONE.
          product_d = acc_sum;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire
